serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor_fs.sv | 14 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of the bit counter. It only has to reach WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a controller (master) and the subtractor (slave).
//
// Handshake: the slave is ready whenever busy is low (IDLE or DONE). A request is
// accepted on any rising edge where start=1 while ready, and a/b are captured on
// that same edge. done is a one-cycle pulse, and diff/borrow_out/overflow/zero are
// valid in that cycle. They then hold until the end of the next accepted
// operation. start is ignored while busy.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Difference bit and borrow out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// It uses a single full-subtractor cell and a registered borrow. The unsigned
// borrow, signed overflow and zero flags are loaded together with the result.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus,
    output state_e               o_state
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_zero;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_final;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // A request is taken whenever the block is not shifting.
    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    // The edge that produces the final (MSB) difference bit.
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
    // The result register after this edge's shift: the new bit enters at the MSB.
    assign w_final  = {w_d, r_res[WIDTH-1:1]};

    // State register; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. DONE lasts one cycle unless a new request arrives in it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? SHIFT : IDLE;
            SHIFT:   w_next = (r_cnt == LAST) ? DONE : SHIFT;
            DONE:    w_next = bus.start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands, shift one bit per edge, load result and flags at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
            r_bin        <= 1'b0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_res <= w_final;
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_bin <= w_bout;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                // The operand shift registers have drained by now, so the sign test uses the MSBs saved at capture.
                r_diff       <= w_final;
                r_borrow_out <= w_bout;
                r_zero       <= (w_final == '0);
                r_overflow   <= (r_a_msb != r_b_msb) && (w_final[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.overflow   = r_overflow;
    assign bus.zero       = r_zero;
    assign o_state        = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 4-bit instance, checked against
// plain-arithmetic subtraction.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    logic   clk;
    logic   rst;
    state_e state8;
    state_e state4;
    int     n_tests;
    int     n_fail;
    logic [7:0] prev_diff;
    logic [7:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(8)) bus8();
    serial_subtractor_if #(.WIDTH(4)) bus4();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus8),
        .o_state (state8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus4),
        .o_state (state4)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: subtraction as ordinary integers.
    function automatic void model(input int w, input longint a, input longint b,
                                  output longint d, output logic bo, output logic ov,
                                  output logic z);
        longint m;
        longint half;
        longint sa;
        longint sb;
        longint sd;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        d    = (a - b) & m;
        bo   = (a < b);
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        sd   = sa - sb;
        ov   = (sd >= half) || (sd < -half);
        z    = (d == 0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver: issues one 8-bit operation and records what the DUT shows. An
    // optional start pulse with other operands goes out mid-shift.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit mid_pulse,
                        output int lat, output int busy_cnt, output logic [7:0] held,
                        output logic [10:0] res);
        bus8.a = a;
        bus8.b = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        held = bus8.diff;
        lat = 0;
        busy_cnt = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) busy_cnt++;
            if (mid_pulse && lat == 2) begin
                bus8.start = 1'b1;
                bus8.a = 8'hFF;
                bus8.b = 8'h00;
            end else begin
                bus8.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus8.start = 1'b0;
        res = {bus8.diff, bus8.borrow_out, bus8.overflow, bus8.zero};
        tick();
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [6:0] res);
        bus4.a = a;
        bus4.b = b;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = {bus4.diff, bus4.borrow_out, bus4.overflow, bus4.zero};
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus8.start = 1'b1;
        bus4.start = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({state8, bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow, bus8.zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset8: got state=%0d busy=%b done=%b diff=%h flags=%b%b%b expected all 0",
                     state8, bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow, bus8.zero);
        end
        n_tests++;
        if ({state4, bus4.busy, bus4.done, bus4.diff, bus4.borrow_out, bus4.overflow, bus4.zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset4: got state=%0d busy=%b done=%b diff=%h expected all 0",
                     state4, bus4.busy, bus4.done, bus4.diff);
        end
        bus8.start = 1'b0;
        bus4.start = 1'b0;
        rst = 1'b0;
        prev_diff = 8'h00;
        tick();
    endtask

    task automatic test_directed;
        logic [7:0]  va[6];
        logic [7:0]  vb[6];
        int          lat;
        int          bcnt;
        logic [7:0]  held;
        logic [10:0] res;
        longint      d;
        logic        bo;
        logic        ov;
        logic        z;
        va = '{8'h50, 8'h20, 8'h80, 8'h7F, 8'hA5, 8'h00};
        vb = '{8'h20, 8'h50, 8'h01, 8'hFF, 8'hA5, 8'h01};
        for (int i = 0; i < 6; i++) begin
            run8(va[i], vb[i], 1'b0, lat, bcnt, held, res);
            model(8, longint'(va[i]), longint'(vb[i]), d, bo, ov, z);
            n_tests++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL latency8[%0d]: got %0d expected 8", i, lat);
            end
            n_tests++;
            if (bcnt != 8) begin
                n_fail++;
                $display("FAIL busy_cycles[%0d]: got %0d expected 8", i, bcnt);
            end
            n_tests++;
            if (held !== prev_diff) begin
                n_fail++;
                $display("FAIL diff_hold[%0d]: got %h expected %h", i, held, prev_diff);
            end
            n_tests++;
            if (res !== {8'(d), bo, ov, z}) begin
                n_fail++;
                $display("FAIL result[%0d] %h-%h: got diff/b/o/z=%h expected %h", i, va[i], vb[i], res, {8'(d), bo, ov, z});
            end
            prev_diff = 8'(d);
        end
    endtask

    task automatic test_random;
        int          lat;
        int          bcnt;
        logic [7:0]  held;
        logic [10:0] res;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  exp_d;
        longint      d;
        logic        bo;
        logic        ov;
        logic        z;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            model(8, longint'(a), longint'(b), d, bo, ov, z);
            exp_q.push_back(8'(d));
            run8(a, b, 1'b0, lat, bcnt, held, res);
            exp_d = exp_q.pop_front();
            n_tests++;
            if (lat != 8 || res !== {exp_d, bo, ov, z}) begin
                n_fail++;
                $display("FAIL random[%0d] %h-%h: got lat=%0d res=%h expected lat=8 res=%h", i, a, b, lat, res, {exp_d, bo, ov, z});
            end
            prev_diff = exp_d;
        end
    endtask

    task automatic test_back_to_back;
        int  n;
        int  lat;
        logic busy_after;
        bus8.a = 8'h10;
        bus8.b = 8'h01;
        bus8.start = 1'b1;
        tick();
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat != 8 || bus8.diff !== 8'h0F) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d diff=%h expected lat=8 diff=0f", lat, bus8.diff);
        end
        n = 0;
        busy_after = 1'b0;
        do begin
            tick();
            n++;
            if (n == 1) busy_after = bus8.busy;
        end while (bus8.done !== 1'b1 && n < 40);
        bus8.start = 1'b0;
        n_tests++;
        if (busy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got busy=%b after done expected 1", busy_after);
        end
        n_tests++;
        if (n != 9 || bus8.diff !== 8'h0F) begin
            n_fail++;
            $display("FAIL b2b_period: got period=%0d diff=%h expected 9 and 0f", n, bus8.diff);
        end
        tick();
        n_tests++;
        if (state8 !== IDLE) begin
            n_fail++;
            $display("FAIL b2b_idle: got state=%0d expected %0d", state8, IDLE);
        end
        prev_diff = 8'h0F;
    endtask

    task automatic test_start_ignored;
        int          lat;
        int          bcnt;
        logic [7:0]  held;
        logic [10:0] res;
        run8(8'h50, 8'h20, 1'b1, lat, bcnt, held, res);
        n_tests++;
        if (lat != 8 || res !== {8'h30, 3'b000}) begin
            n_fail++;
            $display("FAIL start_ignored: got lat=%0d res=%h expected lat=8 res=%h", lat, res, {8'h30, 3'b000});
        end
        tick();
        n_tests++;
        if (state8 !== IDLE || bus8.diff !== 8'h30) begin
            n_fail++;
            $display("FAIL start_ignored_after: got state=%0d diff=%h expected %0d and 30", state8, bus8.diff, IDLE);
        end
        prev_diff = 8'h30;
    endtask

    task automatic test_reset_mid;
        int          lat;
        int          bcnt;
        int          done_seen;
        logic [7:0]  held;
        logic [10:0] res;
        run8(8'h7F, 8'hFF, 1'b0, lat, bcnt, held, res);
        bus8.a = 8'h50;
        bus8.b = 8'h20;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({state8, bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow, bus8.zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got state=%0d busy=%b done=%b diff=%h flags=%b%b%b expected all 0",
                     state8, bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow, bus8.zero);
        end
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1 || state8 !== IDLE) done_seen++;
            tick();
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d non-idle cycles expected 0", done_seen);
        end
        run8(8'h09, 8'h03, 1'b0, lat, bcnt, held, res);
        n_tests++;
        if (lat != 8 || res !== {8'h06, 3'b000}) begin
            n_fail++;
            $display("FAIL after_reset_op: got lat=%0d res=%h expected lat=8 res=%h", lat, res, {8'h06, 3'b000});
        end
        prev_diff = 8'h06;
    endtask

    task automatic test_width4;
        int         lat;
        int         bad;
        logic [6:0] res;
        longint     d;
        logic       bo;
        logic       ov;
        logic       z;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b), lat, res);
                model(4, longint'(a), longint'(b), d, bo, ov, z);
                n_tests++;
                if (lat != 4 || res !== {4'(d), bo, ov, z}) begin
                    n_fail++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL width4 %h-%h: got lat=%0d res=%h expected lat=4 res=%h", a, b, lat, res, {4'(d), bo, ov, z});
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus4.start = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
